// File: rtl/vit_acs_sched.sv
// rtl/vit_acs_sched.sv - Viterbi BMC/ACS time-multiplexing scheduler (optional NORM state via VIT_ACS_SCHED_PM_NORM_EN)
module vit_acs_sched #(
    parameter int GROUPS   = 8,
    parameter int TB_DEPTH = 32,
    localparam int GW = $clog2(GROUPS),
    localparam int AW = $clog2(TB_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sym_valid,
    input  logic [1:0]    sym_pair,
    output logic          sym_ready,
    output logic [1:0]    bmc_pair,
    output logic          acs_en,
    output logic [GW-1:0] grp_idx,
    output logic          pm_swap,
    output logic          surv_wr_en,
    output logic [AW-1:0] surv_wr_addr,
    output logic          tb_start,
    input  logic          norm_req,
    output logic          pm_norm
);

`ifdef VIT_ACS_SCHED_PM_NORM_EN
    typedef enum logic [1:0] {IDLE, RUN, NORM} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN} state_t;
`endif

    state_t state;
    logic   last_grp;

    assign last_grp   = (grp_idx == GW'(GROUPS - 1));
    assign acs_en     = (state == RUN);
    assign surv_wr_en = acs_en;
    assign pm_swap    = acs_en && last_grp;

    // Ready is held low while reset is asserted so nothing is accepted mid-reset.
    always_comb begin
        sym_ready = 1'b0;
        if (!rst) begin
            if (state == IDLE) begin
                sym_ready = 1'b1;
            end else if (state == RUN && last_grp) begin
`ifdef VIT_ACS_SCHED_PM_NORM_EN
                sym_ready = ~norm_req;
`else
                sym_ready = 1'b1;
`endif
            end
        end
    end

`ifndef VIT_ACS_SCHED_PM_NORM_EN
    logic unused_norm_req;
    assign unused_norm_req = norm_req;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            bmc_pair     <= 2'b00;
            grp_idx      <= '0;
            surv_wr_addr <= '0;
            tb_start     <= 1'b0;
            pm_norm      <= 1'b0;
        end else begin
            tb_start <= 1'b0;
            pm_norm  <= 1'b0;
            case (state)
                IDLE: begin
                    if (sym_valid) begin
                        bmc_pair <= sym_pair;
                        grp_idx  <= '0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (!last_grp) begin
                        grp_idx <= grp_idx + GW'(1);
                    end else begin
                        // Symbol completes here: advance survivor row, flag traceback on wrap.
                        surv_wr_addr <= surv_wr_addr + AW'(1);
                        tb_start     <= (surv_wr_addr == AW'(TB_DEPTH - 1));
                        grp_idx      <= '0;
`ifdef VIT_ACS_SCHED_PM_NORM_EN
                        if (norm_req) begin
                            state   <= NORM;
                            pm_norm <= 1'b1;
                        end else
`endif
                        if (sym_valid) begin
                            bmc_pair <= sym_pair;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
`ifdef VIT_ACS_SCHED_PM_NORM_EN
                NORM: state <= IDLE;
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vit_acs_sched.sv
// tb/tb_vit_acs_sched.sv - randomized self-checking bench for vit_acs_sched
module tb_vit_acs_sched;
    localparam int GROUPS   = 8;
    localparam int TB_DEPTH = 32;
    localparam int GW = $clog2(GROUPS);
    localparam int AW = $clog2(TB_DEPTH);
    localparam int NCYC = 2500;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sym_valid = 1'b0;
    logic [1:0]    sym_pair = 2'b00;
    logic          sym_ready;
    logic [1:0]    bmc_pair;
    logic          acs_en;
    logic [GW-1:0] grp_idx;
    logic          pm_swap;
    logic          surv_wr_en;
    logic [AW-1:0] surv_wr_addr;
    logic          tb_start;
    logic          norm_req = 1'b0;
    logic          pm_norm;

    int errors = 0;
    int checks = 0;

    vit_acs_sched #(.GROUPS(GROUPS), .TB_DEPTH(TB_DEPTH)) dut (
        .clk(clk), .rst(rst), .sym_valid(sym_valid), .sym_pair(sym_pair),
        .sym_ready(sym_ready), .bmc_pair(bmc_pair), .acs_en(acs_en),
        .grp_idx(grp_idx), .pm_swap(pm_swap), .surv_wr_en(surv_wr_en),
        .surv_wr_addr(surv_wr_addr), .tb_start(tb_start),
        .norm_req(norm_req), .pm_norm(pm_norm)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: cycles left in the current symbol, completed symbol count, norm cycle flag.
    int   m_busy;
    int   m_syms;
    bit   m_norm;
    bit   m_tb;
    logic [1:0] m_pair;
    bit   m_norm_en;

    function automatic bit exp_ready();
        if (m_norm) return 1'b0;
        if (m_busy == 0) return 1'b1;
        if (m_busy == 1) return m_norm_en ? !norm_req : 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_syms = 0; m_norm = 0; m_tb = 0; m_pair = 2'b00;
    endtask

    task automatic check_all(input string ph);
        check({ph, "_ready"},  32'(sym_ready),    32'(exp_ready()));
        check({ph, "_acs_en"}, 32'(acs_en),       32'(m_busy > 0));
        check({ph, "_wr_en"},  32'(surv_wr_en),   32'(m_busy > 0));
        check({ph, "_grp"},    32'(grp_idx),      32'(m_busy > 0 ? GROUPS - m_busy : 0));
        check({ph, "_swap"},   32'(pm_swap),      32'(m_busy == 1));
        check({ph, "_addr"},   32'(surv_wr_addr), 32'(m_syms % TB_DEPTH));
        check({ph, "_bmc"},    32'(bmc_pair),     32'(m_pair));
        check({ph, "_tb"},     32'(tb_start),     32'(m_tb));
        check({ph, "_norm"},   32'(pm_norm),      32'(m_norm));
    endtask

    task automatic check_reset();
        check("rst_ready", 32'(sym_ready), 32'd0);
        check("rst_acs",   32'(acs_en),    32'd0);
        check("rst_grp",   32'(grp_idx),   32'd0);
        check("rst_swap",  32'(pm_swap),   32'd0);
        check("rst_wr_en", 32'(surv_wr_en), 32'd0);
        check("rst_addr",  32'(surv_wr_addr), 32'd0);
        check("rst_bmc",   32'(bmc_pair),  32'd0);
        check("rst_tb",    32'(tb_start),  32'd0);
        check("rst_norm",  32'(pm_norm),   32'd0);
    endtask

    task automatic model_step();
        bit acc;
        acc  = exp_ready() && sym_valid;
        m_tb = 0;
        if (m_norm) begin
            m_norm = 0;
        end else if (m_busy == 1) begin
            m_syms++;
            if (m_syms % TB_DEPTH == 0) m_tb = 1;
            if (m_norm_en && norm_req) begin
                m_norm = 1; m_busy = 0;
            end else if (acc) begin
                m_busy = GROUPS; m_pair = sym_pair;
            end else begin
                m_busy = 0;
            end
        end else if (m_busy > 1) begin
            m_busy--;
        end else if (acc) begin
            m_busy = GROUPS; m_pair = sym_pair;
        end
    endtask

    initial begin
        int vp;
        bit do_rst;
`ifdef VIT_ACS_SCHED_PM_NORM_EN
        m_norm_en = 1;
`else
        m_norm_en = 0;
`endif
        model_reset();
        #2;
        check_reset();
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            rst = 1'b0;
            vp = (cyc < 600) ? 95 : (cyc < 1200) ? 40 : 80;
            if (cyc < 20) begin
                sym_valid = (cyc == 2);
                sym_pair  = 2'b10;
                norm_req  = 1'b0;
            end else begin
                sym_valid = ($urandom_range(0, 99) < vp);
                sym_pair  = 2'($urandom);
                norm_req  = ($urandom_range(0, 7) == 0);
            end
            do_rst = (cyc == 700) || (cyc == 1500) || ($urandom_range(0, 299) == 0);
            #1;
            check_all("run");
            if (do_rst) begin
                #1 rst = 1'b1;
                #1;
                check_reset();
                model_reset();
                @(posedge clk);
            end else begin
                @(posedge clk);
                model_step();
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vit_acs_sched.md
# vit_acs_sched

Time-multiplexing scheduler for the shared branch-metric / add-compare-select datapath in the Viterbi decoder. It accepts one received symbol pair per handshake and holds it on the shared BMC bank. It then steps the ACS array through `GROUPS` state groups, one group per cycle, and produces the path-metric bank swap, survivor-memory write strobes and addresses, and the traceback start pulse. It sits between the symbol input stage and the BMC/ACS array plus survivor RAM.

## Interface
- `GROUPS`, 8: number of state groups processed per symbol; power of two, ≥2.
- `TB_DEPTH`, 32: survivor-memory rows; power of two, ≥2.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `sym_valid`  in  1  input symbol valid.
- `sym_pair`  in  2  received hard-decision pair.
- `sym_ready`  out  1  scheduler can accept a symbol this cycle.
- `bmc_pair`  out  2  registered symbol driven to the shared BMC bank.
- `acs_en`  out  1  ACS array processes group `grp_idx` this cycle.
- `grp_idx`  out  log2(GROUPS)  current state group.
- `pm_swap`  out  1  last group of the symbol; path-metric ping-pong flips at the end of this cycle.
- `surv_wr_en`  out  1  survivor write strobe, equal to `acs_en`.
- `surv_wr_addr`  out  log2(TB_DEPTH)  survivor row for the current symbol.
- `tb_start`  out  1  one-cycle pulse: TB_DEPTH symbols written since the last pulse.
- `norm_req`  in  1  path-metric overflow warning from the ACS array (macro only).
- `pm_norm`  out  1  normalisation cycle: subtract the minimum metric (macro only).

## Operation
- FSM states: IDLE, RUN, and NORM (NORM exists only with the macro).
- IDLE:
  - `sym_ready`=1.
  - On `sym_valid`: latch `sym_pair` into `bmc_pair`, clear `grp_idx`, go to RUN.
- RUN:
  - `acs_en`=1.
  - `grp_idx` increments by 1 per cycle.
  - `pm_swap`=1 when `grp_idx`==GROUPS-1.
- At the last group (`grp_idx`==GROUPS-1):
  - `sym_ready`=1.
  - On `sym_valid`: latch the new symbol, `grp_idx` wraps to 0, stay in RUN. Back-to-back symbols have no bubble.
  - Otherwise go to IDLE.
- Symbol completion happens at the end of the last-group cycle:
  - `surv_wr_addr` increments modulo TB_DEPTH.
  - When the increment wraps TB_DEPTH-1→0, `tb_start` is 1 for the following cycle only.
- `sym_ready` in RUN is 0 except at the last group. `sym_pair` is ignored when `sym_ready`=0.
- `bmc_pair` holds its value until the next accepted symbol.
- Reset values: state IDLE, `bmc_pair`=0, `grp_idx`=0, `surv_wr_addr`=0. `acs_en`, `pm_swap`, `surv_wr_en`, `tb_start` and `pm_norm` are all 0. `sym_ready`=1 once `rst` is low.
- Reset mid-symbol: the in-flight symbol is discarded and the survivor row is not advanced.

## Timing
- Symbol accepted at edge t → `acs_en` high for cycles t+1 … t+GROUPS, with `grp_idx` 0…GROUPS-1.
- Sustained throughput: one symbol per GROUPS cycles.
- `acs_en`, `grp_idx`, `pm_swap`, `surv_wr_*` and `bmc_pair` are decoded from registers only; there is no combinational path from inputs.
- `sym_ready` is decoded from state and `grp_idx` only.
- `tb_start` is registered and lags the final row write by one cycle.

## Configuration
- Macro `VIT_ACS_SCHED_PM_NORM_EN`.
- Defined:
  - `norm_req` is sampled in the last-group cycle.
  - If `norm_req` is 1, the FSM goes to NORM for exactly one cycle, regardless of `sym_valid`. In that cycle `sym_ready`=0, `acs_en`=0 and `pm_norm`=1.
  - NORM → IDLE.
  - In the last-group cycle, `sym_ready` = ~`norm_req`. This is the only input-dependent ready path.
- Undefined:
  - No NORM state.
  - `norm_req` is ignored.
  - `pm_norm` is tied 0.

## Test plan
- Reset then a single symbol 2'b10 with GROUPS=8 → `acs_en` high 8 cycles, `grp_idx` 0..7, `pm_swap` only at 7, `bmc_pair`=2'b10, `surv_wr_addr`=0 during the symbol and 1 after, return to IDLE.
- `sym_valid` held high with 3 symbols → 24 consecutive `acs_en` cycles with no gap, `bmc_pair` changing at cycles 9 and 17, `surv_wr_addr` 0,1,2.
- 32 continuous symbols with TB_DEPTH=32 → `surv_wr_addr` wraps 31→0 and `tb_start` pulses once, one cycle after the 32nd `pm_swap`; no further pulse until symbol 64.
- `sym_valid` high while `grp_idx`=3 → `sym_ready`=0, symbol not latched, `bmc_pair` unchanged, symbol taken at `grp_idx`=7.
- `rst` asserted at `grp_idx`=4 → all outputs 0 immediately and asynchronously, `surv_wr_addr` stays 0, next symbol starts at `grp_idx`=0.
- With macro, `norm_req`=1 at last group and `sym_valid`=1 → `sym_ready`=0, one `pm_norm` cycle, IDLE, then the symbol is accepted; without macro, the same stimulus gives no gap and `pm_norm` stays 0.
